pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  Execute-stage control-flow resolver and fetch PC sequencer; the producer side of control_hazards_sum and consumer of Hold.
//  Resolves branches/JAL/JALR sitting in execute, steers the fetch PC, and raises control_hazards_sum for the flush window.
//  During the flush window it marks wrong-path instructions in execute as killed.
//  Sits between IMEM address generation and the execute stage of the 3-stage RV32I core.
// PARAMETERS
//  RESET_PC      32'h4000_0000  fetch PC loaded on reset
//  FLUSH_CYCLES  2              cycles control_hazards_sum stays high after a redirect (legal 1..3)
// PORTS
//  clk                 in   1   core clock; every register updates on posedge
//  rst                 in   1   synchronous reset, active-high
//  Hold                in   1   decode load-use stall request; freezes fetch PC
//  Inst_Execute        in   32  instruction currently in execute
//  BrEq                in   1   branch comparator: rs1 == rs2
//  BrLt                in   1   branch comparator: rs1 < rs2 (signedness already chosen by BrUn)
//  alu_result          in   32  ALU output; branch/JAL/JALR target
//  stats_clr           in   1   clear branch counters (used only with BRANCH_STATS_EN)
//  pc_fetch            out  32  registered PC presented to IMEM
//  redirect            out  1   combinational; high in the cycle a taken control transfer resolves
//  control_hazards_sum out  1   registered; high for FLUSH_CYCLES cycles after redirect
//  exec_kill           out  1   registered; equals control_hazards_sum; downstream gates RegWen/MemRW
//  target_misaligned   out  1   1-cycle pulse; a taken target has bit1 set
//  br_count            out  32  conditional branches resolved (0 without BRANCH_STATS_EN)
//  br_taken_count      out  32  conditional branches taken (0 without BRANCH_STATS_EN)
// BEHAVIOUR
//  Reset values:
//   - pc_fetch=RESET_PC, state=RUN, flush counter=0.
//   - control_hazards_sum, exec_kill, target_misaligned: 0.
//   - counters: 0.
//  opcode = Inst_Execute[6:2]:
//   - 11000 = branch; 11011 = JAL; 11001 = JALR.
//   - If Inst_Execute[1:0] != 2'b11, the instruction is non-control.
//  Branch condition on funct3 = Inst_Execute[14:12]:
//   - 000 BrEq; 001 !BrEq; 100/110 BrLt; 101/111 !BrLt.
//   - 010 and 011 are never taken.
//  taken = (state==RUN) & (JAL | JALR | branch & cond).
//  target = {alu_result[31:1], 1'b0}:
//   - bit0 is always cleared; this covers JALR.
//   - bit1 is passed through unchanged, and target_misaligned pulses in the next cycle.
//  State RUN:
//   - If taken: redirect=1, pc_fetch<=target, go to FLUSH, count<=FLUSH_CYCLES-1.
//   - Else if Hold: pc_fetch holds.
//   - Else: pc_fetch<=pc_fetch+4, mod 2^32; 32'hFFFF_FFFC wraps to 0.
//  State FLUSH:
//   - control_hazards_sum=exec_kill=1.
//   - Execute holds wrong-path instructions, so redirects are suppressed (redirect=0).
//   - Hold is ignored; pc_fetch<=pc_fetch+4.
//   - When count==0, return to RUN; otherwise count--.
//  Latency:
//   - Branch in EX at cycle t: IMEM sees target at t+1.
//   - control_hazards_sum is high for t+1..t+FLUSH_CYCLES.
//  Simultaneous events:
//   - taken and Hold in the same cycle: redirect wins, and the PC does not hold.
//   - A redirect on the last FLUSH cycle is ignored.
//  rst asserted mid-FLUSH:
//   - Abort to RUN at pc=RESET_PC.
//   - control_hazards_sum is 0 in the cycle after rst is sampled.
//  Back-to-back taken branches:
//   - The second branch is evaluated only once it reaches EX in RUN.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//   - In RUN, every resolved conditional branch increments br_count.
//   - A taken one also increments br_taken_count.
//   - Both counters wrap at 2^32.
//   - stats_clr zeroes both; a clear in the same cycle as an increment wins.
//  BRANCH_STATS_EN undefined:
//   - Counters are not built; br_count and br_taken_count are tied to 0; stats_clr is ignored.
//   - The port list is identical in both builds.
// TESTING
//  1. Release rst, no Hold, no control instructions -> pc_fetch sequence 4000_0000, 4000_0004, 4000_0008; control_hazards_sum=0.
//  2. BEQ with BrEq=1, alu_result=4000_0100 at cycle t:
//     - redirect=1 at t; pc_fetch=4000_0100 at t+1.
//     - control_hazards_sum=1 for t+1 and t+2, then 0.
//  3. BNE with BrEq=1 -> redirect=0, pc+4. Then Hold=1 for 2 cycles -> pc_fetch frozen, then resumes at +4.
//  4. JALR with alu_result=4000_0207 -> pc_fetch=4000_0206; target_misaligned pulses at t+1.
//     Same instruction with Hold=1 -> redirect still taken.
//  5. Taken JAL, then a taken BEQ present in EX during FLUSH -> BEQ ignored.
//     Then rst during FLUSH -> pc_fetch=RESET_PC and hazard low next cycle.
//  6. With BRANCH_STATS_EN: 3 branches, 2 taken -> br_count=3, br_taken_count=2.
//     stats_clr -> 0,0. Without the macro: both read 0 throughout.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//   Execute-stage control-flow resolver and fetch PC sequencer for the 3-stage
//   RV32I core. It resolves branches, JAL and JALR that sit in execute and
//   steers the fetch PC. After a redirect it raises control_hazards_sum and
//   exec_kill for FLUSH_CYCLES cycles so that wrong-path instructions are
//   squashed.
//
// Parameters
//   RESET_PC      fetch PC loaded on reset
//   FLUSH_CYCLES  length of the flush window after a redirect (1..3)
//
// Optional feature macro
//   BRANCH_STATS_EN  builds the conditional-branch counters. When it is not
//                    defined, br_count and br_taken_count read 0 and
//                    stats_clr is ignored. The port list is the same in both
//                    builds.
//
// Ports
//   clk                 in   core clock
//   rst                 in   synchronous reset, active-high
//   Hold                in   load-use stall; freezes the fetch PC while in RUN
//   Inst_Execute        in   instruction currently in execute
//   BrEq, BrLt          in   branch comparator results
//   alu_result          in   branch/JAL/JALR target from the ALU
//   stats_clr           in   clears the branch counters
//   pc_fetch            out  registered PC presented to IMEM
//   redirect            out  combinational; a taken transfer resolves this cycle
//   control_hazards_sum out  registered; high during the flush window
//   exec_kill           out  registered; same timing as control_hazards_sum
//   target_misaligned   out  registered 1-cycle pulse; taken target had bit1 set
//   br_count            out  conditional branches resolved
//   br_taken_count      out  conditional branches taken
// -----------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h4000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Hold,
  input  logic [31:0] Inst_Execute,
  input  logic        BrEq,
  input  logic        BrLt,
  input  logic [31:0] alu_result,
  input  logic        stats_clr,
  output logic [31:0] pc_fetch,
  output logic        redirect,
  output logic        control_hazards_sum,
  output logic        exec_kill,
  output logic        target_misaligned,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  state_t      state_r, state_nxt_s;
  logic [1:0]  count_r, count_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic        hazard_r;
  logic        kill_r;
  logic        misaligned_r;

  logic        is_32b_s;
  logic        is_branch_s;
  logic        is_jal_s;
  logic        is_jalr_s;
  logic        cond_s;
  logic        taken_s;
  logic [31:0] target_s;
  logic        unused_s;

  // Instruction decode; 16-bit encodings are never treated as control.
  assign is_32b_s    = (Inst_Execute[1:0] == 2'b11);
  assign is_branch_s = is_32b_s & (Inst_Execute[6:2] == 5'b11000);
  assign is_jal_s    = is_32b_s & (Inst_Execute[6:2] == 5'b11011);
  assign is_jalr_s   = is_32b_s & (Inst_Execute[6:2] == 5'b11001);

  // bit0 cleared for JALR semantics; bit1 kept and reported as misaligned.
  assign target_s = {alu_result[31:1], 1'b0};

  // Redirects only resolve in RUN; execute holds wrong-path work during FLUSH.
  assign taken_s  = (state_r == ST_RUN) & (is_jal_s | is_jalr_s | (is_branch_s & cond_s));
  assign redirect = taken_s;

  // Fields of the instruction and target that this block does not look at.
  assign unused_s = &{1'b0, Inst_Execute[31:15], Inst_Execute[11:7], alu_result[0]
`ifndef BRANCH_STATS_EN
                      , stats_clr
`endif
                     };

  // Branch condition selected by funct3.
  always_comb begin
    cond_s = 1'b0;
    case (Inst_Execute[14:12])
      3'b000:  cond_s = BrEq;
      3'b001:  cond_s = ~BrEq;
      3'b100:  cond_s = BrLt;
      3'b110:  cond_s = BrLt;
      3'b101:  cond_s = ~BrLt;
      3'b111:  cond_s = ~BrLt;
      default: cond_s = 1'b0;
    endcase
  end

  // Next-state, flush counter and next fetch PC.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      ST_RUN: begin
        if (taken_s) begin
          // Redirect beats Hold in the same cycle.
          pc_nxt_s    = target_s;
          state_nxt_s = ST_FLUSH;
          count_nxt_s = FLUSH_INIT;
        end else if (Hold) begin
          pc_nxt_s = pc_r;
        end else begin
          pc_nxt_s = pc_r + 32'd4;
        end
      end
      ST_FLUSH: begin
        // Hold is ignored: the stalled instruction is being killed anyway.
        pc_nxt_s = pc_r + 32'd4;
        if (count_r == 2'd0) begin
          state_nxt_s = ST_RUN;
          count_nxt_s = 2'd0;
        end else begin
          count_nxt_s = count_r - 2'd1;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        count_nxt_s = 2'd0;
        pc_nxt_s    = RESET_PC;
      end
    endcase
  end

  // State, PC and registered hazard/kill/misaligned outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_RUN;
      count_r      <= 2'd0;
      pc_r         <= RESET_PC;
      hazard_r     <= 1'b0;
      kill_r       <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      count_r      <= count_nxt_s;
      pc_r         <= pc_nxt_s;
      hazard_r     <= (state_nxt_s == ST_FLUSH);
      kill_r       <= (state_nxt_s == ST_FLUSH);
      misaligned_r <= taken_s & alu_result[1];
    end
  end

  assign pc_fetch            = pc_r;
  assign control_hazards_sum = hazard_r;
  assign exec_kill           = kill_r;
  assign target_misaligned   = misaligned_r;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_r;
  logic [31:0] br_taken_count_r;

  // Conditional-branch counters; only branches resolved in RUN count, clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_r       <= 32'd0;
      br_taken_count_r <= 32'd0;
    end else if (stats_clr) begin
      br_count_r       <= 32'd0;
      br_taken_count_r <= 32'd0;
    end else if ((state_r == ST_RUN) && is_branch_s) begin
      br_count_r       <= br_count_r + 32'd1;
      br_taken_count_r <= br_taken_count_r + {31'd0, cond_s};
    end else begin
      br_count_r       <= br_count_r;
      br_taken_count_r <= br_taken_count_r;
    end
  end

  assign br_count       = br_count_r;
  assign br_taken_count = br_taken_count_r;
`else
  assign br_count       = 32'd0;
  assign br_taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;
  localparam logic [31:0] BF2  = 32'h0000_2063;  // funct3 010: never taken
  localparam logic [31:0] BLT  = 32'h0000_4063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        Hold;
  logic [31:0] Inst_Execute;
  logic        BrEq;
  logic        BrLt;
  logic [31:0] alu_result;
  logic        stats_clr;
  logic [31:0] pc_fetch;
  logic        redirect;
  logic        control_hazards_sum;
  logic        exec_kill;
  logic        target_misaligned;
  logic [31:0] br_count;
  logic [31:0] br_taken_count;

  int errors = 0;
  int checks = 0;

  pc_redirect_unit #(.RESET_PC(32'h4000_0000), .FLUSH_CYCLES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .Hold                (Hold),
    .Inst_Execute        (Inst_Execute),
    .BrEq                (BrEq),
    .BrLt                (BrLt),
    .alu_result          (alu_result),
    .stats_clr           (stats_clr),
    .pc_fetch            (pc_fetch),
    .redirect            (redirect),
    .control_hazards_sum (control_hazards_sum),
    .exec_kill           (exec_kill),
    .target_misaligned   (target_misaligned),
    .br_count            (br_count),
    .br_taken_count      (br_taken_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Hold = 1'b0; Inst_Execute = NOP; BrEq = 1'b0; BrLt = 1'b0;
    alu_result = 32'd0; stats_clr = 1'b0;
    step(); step();
    checks++; if (pc_fetch !== 32'h4000_0000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_fetch, 32'h4000_0000); end
    checks++; if (control_hazards_sum !== 1'b0) begin errors++; $display("FAIL reset_hazard got=%b exp=0", control_hazards_sum); end
    checks++; if (exec_kill !== 1'b0) begin errors++; $display("FAIL reset_kill got=%b exp=0", exec_kill); end
    checks++; if (target_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b exp=0", target_misaligned); end
    checks++; if (br_count !== 32'd0 || br_taken_count !== 32'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", br_count, br_taken_count); end
    rst = 1'b0;
    step();
    checks++; if (pc_fetch !== 32'h4000_0004) begin errors++; $display("FAIL seq_pc1 got=%h exp=%h", pc_fetch, 32'h4000_0004); end
    step();
    checks++; if (pc_fetch !== 32'h4000_0008) begin errors++; $display("FAIL seq_pc2 got=%h exp=%h", pc_fetch, 32'h4000_0008); end
    checks++; if (control_hazards_sum !== 1'b0) begin errors++; $display("FAIL seq_hazard got=%b exp=0", control_hazards_sum); end
  endtask

  task automatic test_beq_taken();
    Inst_Execute = BEQ; BrEq = 1'b1; alu_result = 32'h4000_0100;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect got=%b exp=1", redirect); end
    step();
    checks++; if (pc_fetch !== 32'h4000_0100) begin errors++; $display("FAIL beq_target got=%h exp=%h", pc_fetch, 32'h4000_0100); end
    checks++; if (control_hazards_sum !== 1'b1 || exec_kill !== 1'b1) begin errors++; $display("FAIL beq_flush1 got=%b/%b exp=1/1", control_hazards_sum, exec_kill); end
    Inst_Execute = NOP; BrEq = 1'b0;
    step();
    checks++; if (pc_fetch !== 32'h4000_0104 || control_hazards_sum !== 1'b1) begin errors++; $display("FAIL beq_flush2 got=%h/%b exp=40000104/1", pc_fetch, control_hazards_sum); end
    step();
    checks++; if (pc_fetch !== 32'h4000_0108 || control_hazards_sum !== 1'b0 || exec_kill !== 1'b0) begin errors++; $display("FAIL beq_flush_end got=%h/%b/%b exp=40000108/0/0", pc_fetch, control_hazards_sum, exec_kill); end
  endtask

  task automatic test_not_taken_hold();
    Inst_Execute = BNE; BrEq = 1'b1; alu_result = 32'h4000_0800;
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL bne_redirect got=%b exp=0", redirect); end
    step();
    checks++; if (pc_fetch !== 32'h4000_010C) begin errors++; $display("FAIL bne_pc got=%h exp=%h", pc_fetch, 32'h4000_010C); end
    Inst_Execute = BF2; BrEq = 1'b1; BrLt = 1'b1;
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL f3_010_redirect got=%b exp=0", redirect); end
    step();
    checks++; if (pc_fetch !== 32'h4000_0110) begin errors++; $display("FAIL f3_010_pc got=%h exp=%h", pc_fetch, 32'h4000_0110); end
    Inst_Execute = NOP; BrEq = 1'b0; BrLt = 1'b0; Hold = 1'b1;
    step();
    checks++; if (pc_fetch !== 32'h4000_0110) begin errors++; $display("FAIL hold_pc1 got=%h exp=%h", pc_fetch, 32'h4000_0110); end
    step();
    checks++; if (pc_fetch !== 32'h4000_0110) begin errors++; $display("FAIL hold_pc2 got=%h exp=%h", pc_fetch, 32'h4000_0110); end
    Hold = 1'b0;
    step();
    checks++; if (pc_fetch !== 32'h4000_0114) begin errors++; $display("FAIL hold_resume got=%h exp=%h", pc_fetch, 32'h4000_0114); end
  endtask

  task automatic test_jalr();
    Inst_Execute = JALR; alu_result = 32'h4000_0207;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jalr_redirect got=%b exp=1", redirect); end
    step();
    checks++; if (pc_fetch !== 32'h4000_0206) begin errors++; $display("FAIL jalr_target got=%h exp=%h", pc_fetch, 32'h4000_0206); end
    checks++; if (target_misaligned !== 1'b1) begin errors++; $display("FAIL jalr_misaligned got=%b exp=1", target_misaligned); end
    Inst_Execute = NOP;
    step();
    checks++; if (target_misaligned !== 1'b0 || pc_fetch !== 32'h4000_020A) begin errors++; $display("FAIL jalr_pulse_end got=%b/%h exp=0/4000020a", target_misaligned, pc_fetch); end
    step();
    checks++; if (control_hazards_sum !== 1'b0 || pc_fetch !== 32'h4000_020E) begin errors++; $display("FAIL jalr_drain got=%b/%h exp=0/4000020e", control_hazards_sum, pc_fetch); end
    Inst_Execute = JALR; alu_result = 32'h4000_0300; Hold = 1'b1;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jalr_hold_redirect got=%b exp=1", redirect); end
    step();
    checks++; if (pc_fetch !== 32'h4000_0300 || target_misaligned !== 1'b0) begin errors++; $display("FAIL jalr_hold_target got=%h/%b exp=40000300/0", pc_fetch, target_misaligned); end
    Hold = 1'b0; Inst_Execute = NOP;
    step(); step();
    checks++; if (pc_fetch !== 32'h4000_0308 || control_hazards_sum !== 1'b0) begin errors++; $display("FAIL jalr_hold_drain got=%h/%b exp=40000308/0", pc_fetch, control_hazards_sum); end
  endtask

  task automatic test_flush_suppress();
    Inst_Execute = JAL; alu_result = 32'h4000_0400;
    step();
    checks++; if (pc_fetch !== 32'h4000_0400 || control_hazards_sum !== 1'b1) begin errors++; $display("FAIL jal_target got=%h/%b exp=40000400/1", pc_fetch, control_hazards_sum); end
    Inst_Execute = BEQ; BrEq = 1'b1; alu_result = 32'h4000_0800; Hold = 1'b1;
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL flush_redirect1 got=%b exp=0", redirect); end
    step();
    checks++; if (pc_fetch !== 32'h4000_0404 || control_hazards_sum !== 1'b1) begin errors++; $display("FAIL flush_hold_ignored got=%h/%b exp=40000404/1", pc_fetch, control_hazards_sum); end
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL flush_redirect_last got=%b exp=0", redirect); end
    Inst_Execute = NOP; BrEq = 1'b0; Hold = 1'b0;
    step();
    checks++; if (pc_fetch !== 32'h4000_0408 || control_hazards_sum !== 1'b0) begin errors++; $display("FAIL flush_exit got=%h/%b exp=40000408/0", pc_fetch, control_hazards_sum); end
    Inst_Execute = JAL; alu_result = 32'h4000_0500;
    step();
    checks++; if (pc_fetch !== 32'h4000_0500) begin errors++; $display("FAIL jal2_target got=%h exp=%h", pc_fetch, 32'h4000_0500); end
    Inst_Execute = NOP; rst = 1'b1;
    step();
    checks++; if (pc_fetch !== 32'h4000_0000 || control_hazards_sum !== 1'b0 || exec_kill !== 1'b0) begin errors++; $display("FAIL rst_in_flush got=%h/%b/%b exp=40000000/0/0", pc_fetch, control_hazards_sum, exec_kill); end
    rst = 1'b0;
    step();
    checks++; if (pc_fetch !== 32'h4000_0004 || control_hazards_sum !== 1'b0) begin errors++; $display("FAIL rst_resume got=%h/%b exp=40000004/0", pc_fetch, control_hazards_sum); end
  endtask

  task automatic test_wrap();
    Inst_Execute = JALR; alu_result = 32'hFFFF_FFFC;
    step();
    checks++; if (pc_fetch !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got=%h exp=fffffffc", pc_fetch); end
    Inst_Execute = NOP;
    step();
    checks++; if (pc_fetch !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero got=%h exp=00000000", pc_fetch); end
    step();
    checks++; if (pc_fetch !== 32'h0000_0004 || control_hazards_sum !== 1'b0) begin errors++; $display("FAIL wrap_next got=%h/%b exp=00000004/0", pc_fetch, control_hazards_sum); end
  endtask

  task automatic test_stats();
    logic [31:0] exp_c;
    logic [31:0] exp_t;
    stats_clr = 1'b1; Inst_Execute = NOP;
    step();
    checks++; if (br_count !== 32'd0 || br_taken_count !== 32'd0) begin errors++; $display("FAIL stats_clr got=%0d/%0d exp=0/0", br_count, br_taken_count); end
    stats_clr = 1'b0; Inst_Execute = BEQ; BrEq = 1'b1; alu_result = 32'h0000_1000;
    step();
    exp_c = STATS ? 32'd1 : 32'd0; exp_t = STATS ? 32'd1 : 32'd0;
    checks++; if (br_count !== exp_c || br_taken_count !== exp_t) begin errors++; $display("FAIL stats_beq got=%0d/%0d exp=%0d/%0d", br_count, br_taken_count, exp_c, exp_t); end
    Inst_Execute = NOP; BrEq = 1'b0;
    step(); step();
    Inst_Execute = BNE; BrEq = 1'b1;
    step();
    exp_c = STATS ? 32'd2 : 32'd0; exp_t = STATS ? 32'd1 : 32'd0;
    checks++; if (br_count !== exp_c || br_taken_count !== exp_t) begin errors++; $display("FAIL stats_bne got=%0d/%0d exp=%0d/%0d", br_count, br_taken_count, exp_c, exp_t); end
    Inst_Execute = BLT; BrEq = 1'b0; BrLt = 1'b1; alu_result = 32'h0000_2000;
    step();
    Inst_Execute = NOP; BrLt = 1'b0;
    step(); step();
    exp_c = STATS ? 32'd3 : 32'd0; exp_t = STATS ? 32'd2 : 32'd0;
    checks++; if (br_count !== exp_c || br_taken_count !== exp_t) begin errors++; $display("FAIL stats_total got=%0d/%0d exp=%0d/%0d", br_count, br_taken_count, exp_c, exp_t); end
    Inst_Execute = BEQ; BrEq = 1'b1; stats_clr = 1'b1; alu_result = 32'h0000_3000;
    step();
    checks++; if (br_count !== 32'd0 || br_taken_count !== 32'd0) begin errors++; $display("FAIL stats_clr_wins got=%0d/%0d exp=0/0", br_count, br_taken_count); end
    stats_clr = 1'b0; Inst_Execute = NOP; BrEq = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_not_taken_hold();
    test_jalr();
    test_flush_suppress();
    test_wrap();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
